// File: rtl/multicore_run_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multicore_run_controller_if
// Purpose  : Bundles the host request/report signals and the per-core
//            status/end_process pins of the run controller.
// Signals  : start, abort, core_mask      host -> controller
//            end_process[3:0]             processor -> controller
//            status0..status3             controller -> processor (2b each)
//            busy, done, timeout, aborted,
//            finished[3:0], cycle_count   controller -> host
// Modports : slave  - controller side
//            master - host/harness side
// Revision : 1.0 - initial release
// ============================================================================
interface multicore_run_controller_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic [3:0]       core_mask;
  logic [3:0]       end_process;
  logic [1:0]       status0;
  logic [1:0]       status1;
  logic [1:0]       status2;
  logic [1:0]       status3;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             aborted;
  logic [3:0]       finished;
  logic [CNT_W-1:0] cycle_count;

  modport slave (
    input  start, abort, core_mask, end_process,
    output status0, status1, status2, status3,
    output busy, done, timeout, aborted, finished, cycle_count
  );

  modport master (
    output start, abort, core_mask, end_process,
    input  status0, status1, status2, status3,
    input  busy, done, timeout, aborted, finished, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/multicore_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicore_run_controller
// Purpose  : Sequences one run of the four-core matrix-multiply processor:
//            clear selected cores for one cycle, drive them to RUN, freeze
//            each core as it reports end_process, and report completion,
//            elapsed RUN cycles, abort and watchdog timeout.
// Ports    : clock - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - multicore_run_controller_if.slave (host + core pins)
// Params   : CNT_W          - width of cycle_count / watchdog counter
//            TIMEOUT_CYCLES - RUN-cycle limit, 0 disables the watchdog
// Revision : 1.0 - initial release
// ============================================================================
module multicore_run_controller #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  wire logic                   clock,
  input  wire logic                   rst_n,
  multicore_run_controller_if.slave   bus
);

  localparam logic [1:0] c_ST_HOLD = 2'b00;
  localparam logic [1:0] c_ST_RUN  = 2'b01;
  localparam logic [1:0] c_ST_HALT = 2'b10;

  // Watchdog fires on the edge where the pre-increment count equals this,
  // so the aborting cycle itself is the TIMEOUT_CYCLES-th RUN cycle.
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               c_WD_EN        = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              r_state;
  logic [3:0]          r_mask;
  logic [3:0]          r_finished;
  logic [3:0][1:0]     r_status;
  logic                r_busy;
  logic                r_done;
  logic                r_timeout;
  logic                r_aborted;
  logic [CNT_W-1:0]    r_cycle_count;

  logic [3:0]          w_fin_next;
  logic                w_complete;
  logic                w_wd_hit;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [3:0][1:0]     w_run_status;
  logic [3:0][1:0]     w_init_status;

  // Per-core code: finished -> HALT, enabled -> RUN, disabled -> HOLD.
  function automatic logic [3:0][1:0] status_map(input logic [3:0] mask,
                                                 input logic [3:0] fin);
    logic [3:0][1:0] s;
    for (int i = 0; i < 4; i++) begin
      if (fin[i])       s[i] = c_ST_HALT;
      else if (mask[i]) s[i] = c_ST_RUN;
      else              s[i] = c_ST_HOLD;
    end
    return s;
  endfunction

  always_comb begin
    w_fin_next    = r_finished | (bus.end_process & r_mask);
    w_complete    = (w_fin_next == r_mask);
    w_wd_hit      = c_WD_EN && (r_cycle_count == c_TIMEOUT_LAST);
    w_cnt_inc     = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    w_run_status  = status_map(r_mask, w_fin_next);
    w_init_status = status_map(r_mask, 4'b0000);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mask        <= 4'b0000;
      r_finished    <= 4'b0000;
      r_status      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_aborted     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_status <= '0;
          r_busy   <= 1'b0;
          if (bus.start) begin
            r_finished    <= 4'b0000;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_aborted     <= 1'b0;
            if (bus.core_mask != 4'b0000) begin
              r_mask  <= bus.core_mask;
              r_busy  <= 1'b1;
              r_state <= S_INIT;
            end else begin
              // Empty mask: report an immediate, zero-length run.
              r_done <= 1'b1;
            end
          end
        end

        S_INIT: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_status  <= {4{c_ST_HALT}};
            r_state   <= S_FINISH;
          end else begin
            r_status <= w_init_status;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          r_finished    <= w_fin_next;
          r_cycle_count <= w_cnt_inc;
          if (w_complete || bus.abort || w_wd_hit) begin
            // Completion outranks abort, which outranks the watchdog.
            r_aborted <= !w_complete && bus.abort;
            r_timeout <= !w_complete && !bus.abort && w_wd_hit;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_status  <= {4{c_ST_HALT}};
            r_state   <= S_FINISH;
          end else begin
            r_status <= w_run_status;
          end
        end

        S_FINISH: begin
          r_status <= '0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.status0     = r_status[0];
  assign bus.status1     = r_status[1];
  assign bus.status2     = r_status[2];
  assign bus.status3     = r_status[3];
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.aborted     = r_aborted;
  assign bus.finished    = r_finished;
  assign bus.cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_multicore_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicore_run_controller
// Purpose  : Scoreboard bench for multicore_run_controller. Stimulus pushes
//            the expected run report when a start is issued; monitors pop
//            and compare whenever a done pulse appears.
//            Instance a: default watchdog. Instance b: TIMEOUT_CYCLES=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicore_run_controller;

  typedef struct {
    logic [31:0] cnt;
    logic [3:0]  fin;
    logic        to;
    logic        ab;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clock = ~clock;

  multicore_run_controller_if #(.CNT_W(32)) a ();
  multicore_run_controller_if #(.CNT_W(32)) b ();

  multicore_run_controller #(.CNT_W(32), .TIMEOUT_CYCLES(100000)) dut_a (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  multicore_run_controller #(.CNT_W(32), .TIMEOUT_CYCLES(16)) dut_b (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] c, input logic [3:0] f,
                              input logic t, input logic ab);
    exp_t e;
    e.cnt = c; e.fin = f; e.to = t; e.ab = ab;
    return e;
  endfunction

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (a.done === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_cycle_count", a.cycle_count, e.cnt);
        chk("a_finished",    a.finished,    e.fin);
        chk("a_timeout",     a.timeout,     e.to);
        chk("a_aborted",     a.aborted,     e.ab);
        chk("a_busy_at_done", a.busy,       0);
      end
    end
    if (b.done === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_cycle_count", b.cycle_count, e.cnt);
        chk("b_finished",    b.finished,    e.fin);
        chk("b_timeout",     b.timeout,     e.to);
        chk("b_aborted",     b.aborted,     e.ab);
      end
    end
  end

  // Issue a start on instance a and advance into RUN cycle 1.
  task automatic start_a(input logic [3:0] mask, input exp_t e);
    a.core_mask = mask;
    a.start     = 1'b1;
    qa.push_back(e);
    tick();            // now in INIT
    a.start = 1'b0;
    tick();            // now in RUN cycle 1
  endtask

  function automatic logic [7:0] st_a();
    return {a.status3, a.status2, a.status1, a.status0};
  endfunction

  initial begin
    a.start = 0; a.abort = 0; a.core_mask = 0; a.end_process = 0;
    b.start = 0; b.abort = 0; b.core_mask = 0; b.end_process = 0;

    // ---------------- reset then idle ----------------
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_status", st_a(), 8'h00);
      chk("idle_busy", a.busy, 0);
      chk("idle_done", a.done, 0);
      chk("idle_finished", a.finished, 0);
      chk("idle_cycle_count", a.cycle_count, 0);
    end

    // ---------------- full run, stray start while busy ----------------
    a.core_mask = 4'hF;
    a.start     = 1'b1;
    qa.push_back(mk(40, 4'hF, 0, 0));
    tick();
    a.start = 1'b0;
    chk("init_busy", a.busy, 1);
    chk("init_status", st_a(), 8'h00);
    tick();
    chk("run_status_first", st_a(), 8'h55);
    for (int k = 1; k <= 40; k++) begin
      a.end_process = {k >= 40, k >= 30, k >= 20, k >= 10};
      a.start = (k == 5 || k == 6);
      if (k == 11) chk("core0_halt", st_a(), 8'h56);
      if (k == 31) chk("core0to2_halt", st_a(), 8'h6A);
      tick();
    end
    a.start = 0;
    a.end_process = 0;
    chk("finish_status", st_a(), 8'hAA);
    chk("finish_busy", a.busy, 0);
    tick();
    chk("post_finish_status", st_a(), 8'h00);
    chk("hold_count", a.cycle_count, 40);

    // ---------------- partial mask ----------------
    a.end_process = 4'b0010;
    start_a(4'b0101, mk(8, 4'b0101, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      a.end_process = {1'b0, k >= 8, 1'b1, k >= 5};
      if (k == 3) chk("partial_status_k3", st_a(), 8'h11);
      if (k == 7) chk("partial_status_k7", st_a(), 8'h12);
      tick();
    end
    a.end_process = 0;
    tick();

    // ---------------- abort collides with completion ----------------
    start_a(4'h3, mk(4, 4'h3, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      a.end_process = {2'b00, k >= 4, k >= 2};
      a.abort = (k == 4);
      tick();
    end
    a.abort = 0; a.end_process = 0;
    tick();

    // ---------------- abort alone at RUN cycle 3 ----------------
    start_a(4'h1, mk(3, 4'h0, 0, 1));
    for (int k = 1; k <= 3; k++) begin
      a.abort = (k == 3);
      tick();
    end
    a.abort = 0;
    tick();

    // ---------------- abort during INIT ----------------
    a.core_mask = 4'h2;
    a.start = 1;
    qa.push_back(mk(0, 4'h0, 0, 1));
    tick();
    a.start = 0;
    a.abort = 1;
    tick();
    a.abort = 0;
    tick();

    // ---------------- watchdog (instance b) ----------------
    b.core_mask = 4'h3;
    b.start = 1;
    qb.push_back(mk(16, 4'b0001, 1, 0));
    tick();
    b.start = 0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      b.end_process = {3'b000, k >= 4};
      tick();
    end
    b.end_process = 0;
    chk("wd_busy_after", b.busy, 0);
    tick();
    b.core_mask = 4'h1;
    b.start = 1;
    qb.push_back(mk(2, 4'b0001, 0, 0));
    tick();
    b.start = 0;
    chk("wd_timeout_cleared", b.timeout, 0);
    tick();
    for (int k = 1; k <= 2; k++) begin
      b.end_process = {3'b000, k >= 2};
      tick();
    end
    b.end_process = 0;
    tick();

    // ---------------- reset mid-run ----------------
    a.core_mask = 4'hF;
    a.start = 1;
    tick();
    a.start = 0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      a.end_process = 4'b0001;
      tick();
    end
    chk("pre_reset_finished", a.finished, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_status", st_a(), 8'h00);
    chk("rst_busy", a.busy, 0);
    chk("rst_finished", a.finished, 0);
    chk("rst_count", a.cycle_count, 0);
    a.end_process = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- empty mask ----------------
    a.core_mask = 4'h0;
    a.start = 1;
    qa.push_back(mk(0, 4'h0, 0, 0));
    tick();
    a.start = 0;
    chk("empty_busy", a.busy, 0);
    tick();
    chk("empty_busy_later", a.busy, 0);
    chk("empty_status", st_a(), 8'h00);

    repeat (3) tick();
    chk("a_missing_done", qa.size(), 0);
    chk("b_missing_done", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire

// File: doc/multicore_run_controller.md
Name: multicore_run_controller

Overview:
- Sequences a run of the four-core matrix-multiply processor.
- On a start request it clears the selected cores, then drives their 2-bit status inputs to RUN.
- Watches each core's end_process bit and freezes each core as it finishes.
- Reports completion, elapsed cycles and a watchdog timeout.
- Sits between the host/test harness and the processor's status0..status3 / end_process pins.

Parameters:
- CNT_W, 32: width of cycle_count and of the watchdog counter.
- TIMEOUT_CYCLES, 100000: maximum number of RUN cycles before abort. 0 disables the watchdog.

Ports:
- clock, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: run request, sampled only in IDLE.
- abort, input, 1: host abort, sampled in INIT/RUN.
- core_mask, input, 4: cores to run (bit i = core i), latched on start.
- end_process, input, 4: per-core finished flags from the processor. Level-sensitive; may stay high.
- status0..status3, output, 2 each: core control. 2'b00 HOLD/clear, 2'b01 RUN, 2'b10 HALT.
- busy, output, 1: high in INIT and RUN.
- done, output, 1: one-cycle pulse at the end of every accepted run.
- timeout, output, 1: sticky; set if the run ended by watchdog. Cleared on the next accepted start.
- aborted, output, 1: sticky; set if the run ended by abort. Cleared on the next accepted start.
- finished, output, 4: sticky per-core completion mask for the current/last run.
- cycle_count, output, CNT_W: number of RUN cycles in the current/last run.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All status = 00.
  - busy, done, timeout and aborted = 0.
  - finished = 0, cycle_count = 0.
  - Reset mid-run returns immediately to these values; no done pulse.
- States: IDLE, INIT, RUN, FINISH. All outputs are registered.
- IDLE:
  - All status = 00, busy = 0.
  - start=1 with core_mask!=0 at edge t:
    - Latch the mask; clear finished, cycle_count, timeout and aborted.
    - Go to INIT; busy=1 from t+1.
  - start=1 with core_mask==0: no run. Pulse done at t+1 with cycle_count=0; stay IDLE.
- INIT:
  - Exactly one cycle; all status = 00, so the cores reset their PCs.
  - Go to RUN. Enabled cores see status=01 from cycle t+2.
- RUN:
  - Enabled, unfinished core: status = 01.
  - Disabled core: status = 00.
  - Finished core: status = 10.
  - cycle_count increments once per RUN cycle and saturates at all-ones.
  - At each edge, finished |= end_process & mask. A newly finished core shows status=10 from the next cycle.
  - end_process bits of disabled cores are ignored.
  - Exit to FINISH when any of these holds:
    - (finished | new bits) == mask: normal completion.
    - abort=1: set aborted.
    - TIMEOUT_CYCLES!=0 and cycle_count == TIMEOUT_CYCLES-1 at the edge: set timeout.
  - The exit cycle is counted in cycle_count.
  - Priority on the same edge: completion > abort > timeout. Only one flag is set.
- FINISH:
  - One cycle: done=1, busy=0, all status = 10 so every core is frozen.
  - Next: IDLE, with status back to 00.
  - finished and cycle_count hold until the next accepted start.
- start while busy or in FINISH is ignored; it is not queued.
- abort in IDLE is ignored.
- In INIT, abort goes directly to FINISH with aborted=1 and cycle_count=0.
- An end_process bit already high when RUN is entered counts as finished on the first RUN edge. Cores are expected to deassert it during INIT.

Test Plan:
- Reset then idle:
  - rst_n low 3 cycles, then high, start=0.
  - All status=00, busy=0, done=0, finished=0, cycle_count=0 throughout.
- Full run:
  - core_mask=4'hF, start pulse at t. Model cores raise end_process bits 0,1,2,3 after 10,20,30,40 RUN cycles.
  - Each status goes 00 then 01 at t+2, and becomes 10 the cycle after its bit rises.
  - done pulse follows the last bit; cycle_count=40, finished=4'hF, timeout=0.
- Partial mask:
  - core_mask=4'b0101. end_process[1] forced high throughout; cores 0 and 2 finish after 5 and 8 cycles.
  - status1 and status3 stay 00; finished=4'b0101; cycle_count=8.
- Watchdog:
  - TIMEOUT_CYCLES=16, core_mask=4'h3, core 1 never finishes.
  - done pulses after 16 RUN cycles; timeout=1, finished=4'b0001, cycle_count=16.
  - A second start clears timeout.
- Abort and collisions:
  - abort in the same cycle as the last core's end_process: completion wins, aborted=0.
  - abort alone at RUN cycle 3: aborted=1, cycle_count=3.
  - start pulses while busy produce no extra done pulse.
- Reset mid-run plus empty mask:
  - rst_n low during RUN: all outputs reset asynchronously before the next edge; no done pulse.
  - start with core_mask=0: done one cycle later, busy never high, cycle_count=0.
